// File: rtl/hps_bus_responder.sv
// hps_bus_responder: answers HPS host-bus reads/writes in a 64-byte window
// (ID, STATUS, JOY, POP, SCRATCH, FRAME) and buffers core events for the host.
// Handshake: an access begins when the registered strobe sees hps_cs rise on a
// hitting address; hps_ack rises three edges after the CS assertion and stays
// high (hps_dout valid) until hps_cs is sampled low. The event input is
// valid/ready: a word moves on every edge where evt_valid and evt_ready are high.
module hps_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter logic [31:0] CORE_ID    = 32'h4359_4C58,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] hps_addr,
  input  logic [31:0] hps_din,
  input  logic        hps_rw,
  input  logic        hps_cs,
  output logic [31:0] hps_dout,
  output logic        hps_ack,
  input  logic [31:0] joy_data,
  input  logic        vblank,
  input  logic [31:0] evt_data,
  input  logic        evt_valid,
  output logic        evt_ready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_ID      = 4'd0;
  localparam logic [3:0] OFF_STATUS  = 4'd1;
  localparam logic [3:0] OFF_JOY     = 4'd2;
  localparam logic [3:0] OFF_POP     = 4'd3;
  localparam logic [3:0] OFF_SCRATCH = 4'd4;
  localparam logic [3:0] OFF_FRAME   = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ACK} state_t;

  // state is the observation point for anyone probing the access sequence
  state_t state, state_next;

  logic        cs_q, start_q, hit, access_start;
  logic [3:0]  acc_off;
  logic        acc_rw;
  logic [31:0] acc_din;
  logic        do_capture, do_release;
  logic [31:0] rdata;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop;

  logic        stall, irq_en, vblank_q, vblank_rise;
  logic [31:0] joy_reg, scratch, frame;
  logic        wr_status, wr_scratch, wr_frame;

  // byte lanes are not decoded; the word offset alone selects the register
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, hps_addr[1:0]};

  assign hit          = (hps_addr[31:6] == BASE_ADDR[31:6]);
  assign access_start = hps_cs & ~cs_q & hit;

  // strobe edge detector and access latch; cs_q resets high so a CS held
  // through reset release is not mistaken for a new access
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      start_q <= 1'b0;
      acc_off <= '0;
      acc_rw  <= 1'b0;
      acc_din <= '0;
    end else begin
      cs_q    <= hps_cs;
      start_q <= access_start;
      if (access_start) begin
        acc_off <= hps_addr[5:2];
        acc_rw  <= hps_rw;
        acc_din <= hps_din;
      end
    end
  end

  // access FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // access FSM next state and one-cycle action strobes
  always_comb begin
    state_next = state;
    do_capture = 1'b0;
    do_release = 1'b0;
    case (state)
      S_IDLE:    if (start_q) state_next = S_CAPTURE;
      S_CAPTURE: begin
        do_capture = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: if (!hps_cs) begin
        do_release = 1'b1;
        state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  assign hps_ack = (state == S_ACK);

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign evt_ready = ~full;
  assign push      = evt_valid & evt_ready;
  assign pop       = do_capture & ~acc_rw & (acc_off == OFF_POP) & ~empty;

  assign wr_status  = do_capture & acc_rw & (acc_off == OFF_STATUS);
  assign wr_scratch = do_capture & acc_rw & (acc_off == OFF_SCRATCH);
  assign wr_frame   = do_capture & acc_rw & (acc_off == OFF_FRAME);

  assign vblank_rise = vblank & ~vblank_q;

  // read mux for the latched offset; evaluated during CAPTURE
  always_comb begin
    rdata = '0;
    case (acc_off)
      OFF_ID:      rdata = CORE_ID;
      OFF_STATUS:  rdata = {20'd0, irq_en, stall, full, empty, 8'(count)};
      OFF_JOY:     rdata = joy_reg;
      OFF_POP:     rdata = empty ? 32'd0 : mem[rd_ptr];
      OFF_SCRATCH: rdata = scratch;
      OFF_FRAME:   rdata = frame;
      default:     rdata = '0;
    endcase
  end

  // read data is frozen at CAPTURE and cleared when the access ends
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)          hps_dout <= '0;
    else if (do_capture) hps_dout <= acc_rw ? 32'd0 : rdata;
    else if (do_release) hps_dout <= '0;
  end

  // event FIFO pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // event FIFO storage
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= evt_data;
  end

  // control/status registers, vblank capture and interrupt output
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stall    <= 1'b0;
      irq_en   <= 1'b0;
      vblank_q <= 1'b0;
      joy_reg  <= '0;
      scratch  <= '0;
      frame    <= '0;
      irq      <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (evt_valid && !evt_ready)        stall <= 1'b1;
      else if (wr_status && acc_din[10])  stall <= 1'b0;
      if (wr_status)  irq_en  <= acc_din[11];
      if (wr_scratch) scratch <= acc_din;
      if (vblank_rise) joy_reg <= joy_data;
      // a host clear wins over a coincident vblank edge
      if (wr_frame)         frame <= '0;
      else if (vblank_rise) frame <= frame + 32'd1;
      irq <= irq_en & ~empty;
    end
  end
endmodule

// File: tb/tb_hps_bus_responder.sv
// Bench for hps_bus_responder: reset checks, a vector table of bus accesses,
// hand sequences for FIFO/IRQ/vblank/reset corners, and a randomized phase
// checked against a queue-based model of the register window.
module tb_hps_bus_responder;
  localparam logic [31:0] CORE_ID = 32'h4359_4C58;
  localparam int          DEPTH   = 16;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] hps_addr = '0, hps_din = '0, joy_data = '0, evt_data = '0;
  logic        hps_rw = 1'b0, hps_cs = 1'b0, vblank = 1'b0, evt_valid = 1'b0;
  logic [31:0] hps_dout;
  logic        hps_ack, evt_ready, irq;

  hps_bus_responder #(
    .BASE_ADDR(32'h0000_0100), .CORE_ID(CORE_ID), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .hps_addr(hps_addr), .hps_din(hps_din),
    .hps_rw(hps_rw), .hps_cs(hps_cs), .hps_dout(hps_dout), .hps_ack(hps_ack),
    .joy_data(joy_data), .vblank(vblank), .evt_data(evt_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .irq(irq)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // reference model of the window
  logic [31:0] exp_q[$];
  logic [31:0] m_scratch, m_frame, m_joy;
  logic        m_stall, m_irq_en;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] din;
    logic        hit;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [19];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_status();
    int n = exp_q.size();
    return {20'd0, m_irq_en, m_stall, n == DEPTH, n == 0, 8'(n)};
  endfunction

  // one complete bus access, started and finished on a falling edge
  task automatic bus_access(input logic [31:0] addr, input logic rw, input logic [31:0] din,
                            input logic exp_hit, input logic [31:0] exp, input string name);
    int lat = 0;
    logic seen = 1'b0;
    hps_addr = addr; hps_rw = rw; hps_din = din; hps_cs = 1'b1;
    if (exp_hit) begin
      while (!hps_ack && lat < 10) begin
        @(negedge clk_sys);
        lat++;
      end
      check({name, " ack latency"}, lat, 3);
      if (!rw) check({name, " dout"}, hps_dout, exp);
      hps_cs = 1'b0;
      @(negedge clk_sys);
      check({name, " ack release"}, hps_ack, 0);
      check({name, " dout release"}, hps_dout, 0);
    end else begin
      repeat (20) begin
        @(negedge clk_sys);
        if (hps_ack || hps_dout != 0) seen = 1'b1;
      end
      check({name, " miss no ack"}, seen, 0);
      hps_cs = 1'b0;
      @(negedge clk_sys);
    end
  endtask

  // offer one event for exactly one edge
  task automatic push_event(input logic [31:0] d, input logic exp_rdy);
    evt_valid = 1'b1; evt_data = d;
    check("evt_ready", evt_ready, exp_rdy);
    @(negedge clk_sys);
    evt_valid = 1'b0;
  endtask

  task automatic vblank_pulse(input logic [31:0] j);
    joy_data = j; vblank = 1'b1;
    repeat (2) @(negedge clk_sys);
    vblank = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp, r, addr;
    int op, sel;
    logic seen;

    // reset values
    repeat (3) @(negedge clk_sys);
    check("rst ack", hps_ack, 0);
    check("rst dout", hps_dout, 0);
    check("rst irq", irq, 0);
    check("rst evt_ready", evt_ready, 1);
    rst_n = 1'b1;
    @(negedge clk_sys);
    bus_access(32'h104, 0, 0, 1, 32'h0000_0100, "rst status");

    // vector table
    vecs[0]  = '{32'h100, 1'b0, 32'h0,         1'b1, CORE_ID};
    vecs[1]  = '{32'h110, 1'b1, 32'hA5A5_5A5A, 1'b1, 32'h0};
    vecs[2]  = '{32'h110, 1'b0, 32'h0,         1'b1, 32'hA5A5_5A5A};
    vecs[3]  = '{32'h100, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[4]  = '{32'h100, 1'b0, 32'h0,         1'b1, CORE_ID};
    vecs[5]  = '{32'h108, 1'b1, 32'h1234_5678, 1'b1, 32'h0};
    vecs[6]  = '{32'h108, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{32'h118, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[8]  = '{32'h118, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{32'h13C, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{32'h113, 1'b0, 32'h0,         1'b1, 32'hA5A5_5A5A};
    vecs[11] = '{32'h10C, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{32'h10C, 1'b1, 32'h99,        1'b1, 32'h0};
    vecs[13] = '{32'h104, 1'b0, 32'h0,         1'b1, 32'h0000_0100};
    vecs[14] = '{32'h200, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[15] = '{32'h0FC, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[16] = '{32'h310, 1'b1, 32'h1,         1'b0, 32'h0};
    vecs[17] = '{32'h140, 1'b1, 32'h2,         1'b0, 32'h0};
    vecs[18] = '{32'h110, 1'b0, 32'h0,         1'b1, 32'hA5A5_5A5A};
    for (int i = 0; i < 19; i++)
      bus_access(vecs[i].addr, vecs[i].rw, vecs[i].din, vecs[i].hit, vecs[i].exp, $sformatf("vec%0d", i));

    // fill past full, then drain
    for (int i = 0; i < 18; i++) push_event(32'(i), i < DEPTH);
    check("full evt_ready", evt_ready, 0);
    bus_access(32'h104, 0, 0, 1, 32'h0000_0610, "full status");
    for (int i = 0; i < 17; i++)
      bus_access(32'h10C, 0, 0, 1, (i < DEPTH) ? 32'(i) : 32'h0, $sformatf("drain%0d", i));
    bus_access(32'h104, 0, 0, 1, 32'h0000_0500, "drained status");
    bus_access(32'h104, 1, 32'h400, 1, 0, "clear stall");
    bus_access(32'h104, 0, 0, 1, 32'h0000_0100, "cleared status");

    // push and pop on the same edge
    push_event(32'hA0, 1);
    push_event(32'hB0, 1);
    hps_addr = 32'h10C; hps_rw = 1'b0; hps_cs = 1'b1;
    repeat (2) @(negedge clk_sys);
    evt_valid = 1'b1; evt_data = 32'hC0;
    @(negedge clk_sys);
    evt_valid = 1'b0;
    check("pp ack", hps_ack, 1);
    check("pp dout", hps_dout, 32'hA0);
    hps_cs = 1'b0;
    @(negedge clk_sys);
    bus_access(32'h104, 0, 0, 1, 32'h0000_0002, "pp status");
    bus_access(32'h10C, 0, 0, 1, 32'hB0, "pp pop1");
    bus_access(32'h10C, 0, 0, 1, 32'hC0, "pp pop2");

    // pop while full with an event waiting
    for (int i = 0; i < DEPTH; i++) push_event(32'h100 + 32'(i), 1);
    evt_valid = 1'b1; evt_data = 32'hEE;
    check("fp ready full", evt_ready, 0);
    hps_addr = 32'h10C; hps_rw = 1'b0; hps_cs = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("fp ack", hps_ack, 1);
    check("fp dout", hps_dout, 32'h100);
    check("fp ready after pop", evt_ready, 1);
    @(negedge clk_sys);
    evt_valid = 1'b0;
    check("fp ready refilled", evt_ready, 0);
    hps_cs = 1'b0;
    @(negedge clk_sys);
    for (int i = 1; i < DEPTH; i++)
      bus_access(32'h10C, 0, 0, 1, 32'h100 + 32'(i), $sformatf("fp drain%0d", i));
    bus_access(32'h10C, 0, 0, 1, 32'hEE, "fp last");
    bus_access(32'h104, 0, 0, 1, 32'h0000_0500, "fp status");
    bus_access(32'h104, 1, 32'h400, 1, 0, "fp clear stall");

    // interrupt
    bus_access(32'h104, 1, 32'h800, 1, 0, "irq enable");
    bus_access(32'h104, 0, 0, 1, 32'h0000_0900, "irq status");
    check("irq idle", irq, 0);
    push_event(32'h77, 1);
    repeat (2) @(negedge clk_sys);
    check("irq set", irq, 1);
    hps_addr = 32'h10C; hps_rw = 1'b0; hps_cs = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("irq pop dout", hps_dout, 32'h77);
    check("irq at pop", irq, 1);
    @(negedge clk_sys);
    check("irq after pop", irq, 0);
    hps_cs = 1'b0;
    @(negedge clk_sys);
    bus_access(32'h104, 1, 32'h0, 1, 0, "irq disable");

    // frame counter and joystick
    repeat (3) vblank_pulse(32'h12);
    bus_access(32'h114, 0, 0, 1, 32'd3, "frame3");
    bus_access(32'h108, 0, 0, 1, 32'h12, "joy");
    hps_addr = 32'h114; hps_rw = 1'b1; hps_din = 0; hps_cs = 1'b1;
    repeat (2) @(negedge clk_sys);
    vblank = 1'b1;
    @(negedge clk_sys);
    check("fw ack", hps_ack, 1);
    hps_cs = 1'b0;
    @(negedge clk_sys);
    vblank = 1'b0;
    @(negedge clk_sys);
    bus_access(32'h114, 0, 0, 1, 32'd0, "frame write wins");
    joy_data = 32'h34;
    hps_addr = 32'h114; hps_rw = 1'b0; hps_cs = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("hold ack", hps_ack, 1);
    vblank = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("hold dout", hps_dout, 32'd0);
    vblank = 1'b0;
    hps_cs = 1'b0;
    @(negedge clk_sys);
    bus_access(32'h114, 0, 0, 1, 32'd1, "frame after hold");
    bus_access(32'h108, 0, 0, 1, 32'h34, "joy after hold");

    // reset during ACK with CS held through release
    push_event(32'h55, 1);
    bus_access(32'h104, 1, 32'h800, 1, 0, "rst irq enable");
    repeat (2) @(negedge clk_sys);
    check("pre-reset irq", irq, 1);
    hps_addr = 32'h100; hps_rw = 1'b0; hps_cs = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("pre-reset ack", hps_ack, 1);
    rst_n = 1'b0;
    #1;
    check("mid-reset ack", hps_ack, 0);
    check("mid-reset dout", hps_dout, 0);
    check("mid-reset irq", irq, 0);
    check("mid-reset ready", evt_ready, 1);
    @(negedge clk_sys);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk_sys);
      if (hps_ack) seen = 1'b1;
    end
    check("held cs no ack", seen, 0);
    hps_cs = 1'b0;
    @(negedge clk_sys);
    bus_access(32'h104, 0, 0, 1, 32'h0000_0100, "post-reset status");
    bus_access(32'h110, 0, 0, 1, 32'h0, "post-reset scratch");
    bus_access(32'h114, 0, 0, 1, 32'h0, "post-reset frame");
    bus_access(32'h108, 0, 0, 1, 32'h0, "post-reset joy");

    // randomized phase against the model
    exp_q.delete();
    m_scratch = 0; m_frame = 0; m_joy = 0; m_stall = 0; m_irq_en = 0;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 8);
      r = $urandom;
      addr = 32'h100 | 32'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          push_event(r, exp_q.size() < DEPTH);
          if (exp_q.size() < DEPTH) exp_q.push_back(r);
          else m_stall = 1'b1;
        end
        2: begin
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          else exp = 0;
          bus_access(addr | 32'hC, 0, 0, 1, exp, "rnd pop");
        end
        3: bus_access(addr | 32'h4, 0, 0, 1, model_status(), "rnd status");
        4: begin
          bus_access(addr | 32'h10, 1, r, 1, 0, "rnd scratch wr");
          m_scratch = r;
        end
        5: begin
          sel = $urandom_range(0, 3);
          case (sel)
            0:       bus_access(addr,          0, 0, 1, CORE_ID,   "rnd id");
            1:       bus_access(addr | 32'h8,  0, 0, 1, m_joy,     "rnd joy");
            2:       bus_access(addr | 32'h10, 0, 0, 1, m_scratch, "rnd scratch");
            default: bus_access(addr | 32'h14, 0, 0, 1, m_frame,   "rnd frame");
          endcase
        end
        6: begin
          bus_access(addr | 32'h4, 1, r, 1, 0, "rnd status wr");
          if (r[10]) m_stall = 1'b0;
          m_irq_en = r[11];
        end
        7: begin
          vblank_pulse(r);
          m_frame = m_frame + 1;
          m_joy = r;
        end
        default: begin
          bus_access(addr | 32'h14, 1, r, 1, 0, "rnd frame wr");
          m_frame = 0;
        end
      endcase
      repeat (2) @(negedge clk_sys);
      check("rnd irq", irq, m_irq_en && exp_q.size() > 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
